snake_move_ctrl: RTL and testbench

Sequences the snake game datapath. Synchronises and debounces the four direction buttons, arbitrates simultaneous presses and rejects reversals. Paces snake movement to an integer number of VGA frames and issues a req/ack step handshake to the game-state datapath. Also handles start, game-over halt and restart. Sits between the chip-level io_in buttons and the snake state/VGA renderer.

---
 rtl/snake_pkg.sv | 24 ++
 rtl/button_debounce.sv | 52 +++++
 rtl/snake_move_ctrl.sv | 170 +++++++++++++++++
 tb/tb_snake_move_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types for the snake movement controller: directions, FSM states
// and the reversal helper.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        REQ  = 2'd2,
        HALT = 2'd3
    } ctrl_state_t;

    // Opposite directions differ only in bit 0 (UP/DOWN, LEFT/RIGHT).
    function automatic dir_t reverse(input dir_t d);
        return dir_t'(d ^ 2'b01);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// One button: 2-FF synchroniser, debounce counter, and a single-cycle pulse
// on each debounced 0->1 transition.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_button,
    output logic o_press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync_d  = {sync_q[0], i_button};
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        // Any sample that agrees with the accepted level restarts the run.
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q[1];
                press_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_press = press_q;

endmodule

// File: rtl/snake_move_ctrl.sv
// Snake movement sequencer: button arbitration and reversal filtering,
// frame-paced step requests with req/ack handshake, halt and restart.
module snake_move_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned TICK_FRAMES     = 8,
    parameter int unsigned MIN_FRAMES      = 2
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic       i_up,
    input  logic       i_down,
    input  logic       i_left,
    input  logic       i_right,
    input  logic       i_frame_start,
    input  logic       i_step_ack,
    input  logic       i_speed_up,
    input  logic       i_game_over,
    output logic       o_step_req,
    output logic [1:0] o_dir,
    output logic       o_restart,
    output logic       o_running,
    output logic       o_overrun
);

    localparam int unsigned FW = $clog2(TICK_FRAMES + 1);
    localparam logic [FW-1:0] INTERVAL_INIT = FW'(TICK_FRAMES);
    localparam logic [FW-1:0] INTERVAL_MIN  = FW'(MIN_FRAMES);

    logic [3:0] press;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .i_clock(i_clock), .i_reset_n(i_reset_n), .i_button(i_up),    .o_press(press[0]));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .i_clock(i_clock), .i_reset_n(i_reset_n), .i_button(i_down),  .o_press(press[1]));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
        .i_clock(i_clock), .i_reset_n(i_reset_n), .i_button(i_left),  .o_press(press[2]));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
        .i_clock(i_clock), .i_reset_n(i_reset_n), .i_button(i_right), .o_press(press[3]));

    ctrl_state_t   state_q, state_d;
    dir_t          dir_q, dir_d;
    dir_t          pending_q, pending_d;
    logic [FW-1:0] interval_q, interval_d;
    logic [FW-1:0] count_q, count_d;
    logic          req_q, req_d;
    logic          restart_q, restart_d;
    logic          running_q, running_d;
    logic          overrun_q, overrun_d;

    logic cand_valid;
    dir_t cand;
    logic accept;

    always_comb begin
        cand_valid = |press;
        if (press[0])      cand = DIR_UP;
        else if (press[1]) cand = DIR_DOWN;
        else if (press[2]) cand = DIR_LEFT;
        else               cand = DIR_RIGHT;
        accept = cand_valid && (cand != dir_q) && (cand != reverse(dir_q));
    end

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        pending_d  = pending_q;
        interval_d = interval_q;
        count_d    = count_q;
        req_d      = req_q;
        restart_d  = 1'b0;
        overrun_d  = overrun_q;

        if (i_speed_up && (interval_q > INTERVAL_MIN))
            interval_d = interval_q - 1'b1;

        case (state_q)
            IDLE: begin
                if (cand_valid) begin
                    state_d   = WAIT;
                    pending_d = cand;
                    count_d   = '0;
                end
            end
            WAIT: begin
                if (i_game_over) begin
                    state_d = HALT;
                    req_d   = 1'b0;
                end else begin
                    if (accept)
                        pending_d = cand;
                    // >= keeps pacing sane if a speed-up shrinks the interval below count.
                    if (i_frame_start) begin
                        if (count_q >= interval_q - 1'b1) begin
                            state_d = REQ;
                            req_d   = 1'b1;
                            count_d = '0;
                            // A reversal that slipped into pending at the previous commit is dropped here.
                            if (pending_q != reverse(dir_q))
                                dir_d = pending_q;
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                end
            end
            REQ: begin
                if (i_game_over) begin
                    state_d = HALT;
                    req_d   = 1'b0;
                end else begin
                    if (accept)
                        pending_d = cand;
                    if (i_frame_start)
                        overrun_d = 1'b1;
                    if (i_step_ack) begin
                        state_d = WAIT;
                        req_d   = 1'b0;
                    end
                end
            end
            HALT: begin
                req_d = 1'b0;
                if (cand_valid) begin
                    state_d    = IDLE;
                    restart_d  = 1'b1;
                    dir_d      = DIR_RIGHT;
                    pending_d  = DIR_RIGHT;
                    interval_d = INTERVAL_INIT;
                    count_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        running_d = (state_d == WAIT) || (state_d == REQ);
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state_q    <= IDLE;
            dir_q      <= DIR_RIGHT;
            pending_q  <= DIR_RIGHT;
            interval_q <= INTERVAL_INIT;
            count_q    <= '0;
            req_q      <= 1'b0;
            restart_q  <= 1'b0;
            running_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            pending_q  <= pending_d;
            interval_q <= interval_d;
            count_q    <= count_d;
            req_q      <= req_d;
            restart_q  <= restart_d;
            running_q  <= running_d;
            overrun_q  <= overrun_d;
        end
    end

    assign o_step_req = req_q;
    assign o_dir      = dir_q;
    assign o_restart  = restart_q;
    assign o_running  = running_q;
    assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Directed bench for snake_move_ctrl with short debounce and frame intervals.
module tb_snake_move_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic       frame_start = 1'b0, step_ack = 1'b0, speed_up = 1'b0, game_over = 1'b0;
    logic       step_req, restart, running, overrun;
    logic [1:0] dir;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned up_presses = 0;

    snake_move_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .TICK_FRAMES(3),
        .MIN_FRAMES(2)
    ) u_dut (
        .i_clock(clk),
        .i_reset_n(rst_n),
        .i_up(up),
        .i_down(down),
        .i_left(left),
        .i_right(right),
        .i_frame_start(frame_start),
        .i_step_ack(step_ack),
        .i_speed_up(speed_up),
        .i_game_over(game_over),
        .o_step_req(step_req),
        .o_dir(dir),
        .o_restart(restart),
        .o_running(running),
        .o_overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (u_dut.press[0]) up_presses++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame();
        step(2);
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
    endtask

    task automatic ack();
        step_ack = 1'b1;
        step(1);
        step_ack = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req"},     32'(step_req), 0);
        check({tag, "_dir"},     32'(dir),      3);
        check({tag, "_restart"}, 32'(restart),  0);
        check({tag, "_running"}, 32'(running),  0);
        check({tag, "_overrun"}, 32'(overrun),  0);
    endtask

    initial begin
        step(2);
        check_reset_values("rst");
        rst_n = 1'b1;

        // Start from IDLE with RIGHT; press reaches FSM 7 edges after the level change.
        right = 1'b1;
        step(6);
        check("start_early", 32'(running), 0);
        step(1);
        check("start_running", 32'(running), 1);
        right = 1'b0;
        step(8);
        frame();
        frame();
        check("t1_req_f2", 32'(step_req), 0);
        frame();
        check("t1_req_f3", 32'(step_req), 1);
        check("t1_dir", 32'(dir), 3);
        step(2);
        check("t1_req_held", 32'(step_req), 1);
        ack();
        check("t1_req_drop", 32'(step_req), 0);
        check("t1_running", 32'(running), 1);

        // Reversal rejected; simultaneous UP+DOWN resolves to UP.
        left = 1'b1;
        step(7);
        left = 1'b0;
        step(8);
        frame(); frame(); frame();
        check("t3_rev_req", 32'(step_req), 1);
        check("t3_rev_dir", 32'(dir), 3);
        ack();
        up = 1'b1;
        down = 1'b1;
        step(7);
        up = 1'b0;
        down = 1'b0;
        step(8);
        frame(); frame(); frame();
        check("t3_arb_req", 32'(step_req), 1);
        check("t3_arb_dir", 32'(dir), 0);

        // Frames during REQ are not counted and set sticky overrun.
        frame();
        frame();
        check("t4_req_held", 32'(step_req), 1);
        check("t4_overrun", 32'(overrun), 1);
        ack();
        frame();
        frame();
        check("t4_after_f2", 32'(step_req), 0);
        frame();
        check("t4_after_f3", 32'(step_req), 1);
        check("t4_overrun_sticky", 32'(overrun), 1);
        ack();

        // Two speed-ups: 3 -> 2, second saturates at 2.
        speed_up = 1'b1;
        step(1);
        speed_up = 1'b0;
        step(1);
        speed_up = 1'b1;
        step(1);
        speed_up = 1'b0;
        frame();
        check("t5_f1", 32'(step_req), 0);
        frame();
        check("t5_f2", 32'(step_req), 1);
        ack();

        // Press coinciding with commit: RIGHT accepted against old UP, re-filtered against new LEFT.
        left = 1'b1;
        step(7);
        left = 1'b0;
        step(8);
        frame();
        check("t7_f1", 32'(step_req), 0);
        right = 1'b1;
        step(6);
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
        check("t7_commit_req", 32'(step_req), 1);
        check("t7_commit_dir", 32'(dir), 2);
        right = 1'b0;
        step(8);
        ack();
        frame();
        frame();
        check("t7_next_req", 32'(step_req), 1);
        check("t7_next_dir", 32'(dir), 2);

        // Game over wins over a same-cycle ack.
        game_over = 1'b1;
        step_ack = 1'b1;
        step(1);
        game_over = 1'b0;
        step_ack = 1'b0;
        check("t6_halt_req", 32'(step_req), 0);
        check("t6_halt_running", 32'(running), 0);
        check("t6_halt_dir", 32'(dir), 2);
        frame();
        check("t6_halt_no_req", 32'(step_req), 0);
        right = 1'b1;
        step(6);
        check("t6_restart_early", 32'(restart), 0);
        step(1);
        check("t6_restart", 32'(restart), 1);
        check("t6_restart_dir", 32'(dir), 3);
        check("t6_restart_running", 32'(running), 0);
        step(1);
        check("t6_restart_pulse", 32'(restart), 0);
        right = 1'b0;
        step(8);

        // Bouncing UP in IDLE: one press event, none before 4 stable samples.
        up_presses = 0;
        up = 1'b1;
        step(1);
        up = 1'b0;
        step(1);
        up = 1'b1;
        step(6);
        check("t2_bounce_early", 32'(running), 0);
        step(1);
        check("t2_bounce_running", 32'(running), 1);
        up = 1'b0;
        step(8);
        check("t2_single_press", 32'(up_presses), 1);
        frame();
        frame();
        check("t2_interval_reset", 32'(step_req), 0);
        frame();
        check("t2_req", 32'(step_req), 1);
        check("t2_dir", 32'(dir), 0);

        // Reset mid-handshake.
        rst_n = 1'b0;
        step(1);
        check_reset_values("midreq_rst");
        rst_n = 1'b1;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
